// File: rtl/ex_branch_unit.sv
// Execute-stage ALU with a registered result, ID-stage branch comparator,
// and redirect-PC / IF-ID flush generation for the 5-stage RV32I pipeline.
module ex_branch_unit #(
    parameter int XLEN = 32,
    parameter int PCW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [3:0]      alu_sel,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] alu_result_q,
    input  logic [XLEN-1:0] br_a,
    input  logic [XLEN-1:0] br_b,
    input  logic            br_u,
    output logic            br_eq,
    output logic            br_lt,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [PCW-1:0]  if_id_pc,
    input  logic            branch_indicator,
    input  logic            stall,
    output logic            branch,
    output logic [PCW-1:0]  pc_branch
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    logic [4:0] shamt;
    logic       alu_lt_s;
    logic       alu_lt_u;
    logic       imm_hi_unused;

    assign shamt    = alu_b[4:0];
    assign alu_lt_s = $signed(alu_a) < $signed(alu_b);
    assign alu_lt_u = alu_a < alu_b;

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            OP_ADD:   alu_result = alu_a + alu_b;
            OP_SUB:   alu_result = alu_a - alu_b;
            OP_SLL:   alu_result = alu_a << shamt;
            OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, alu_lt_s};
            OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, alu_lt_u};
            OP_XOR:   alu_result = alu_a ^ alu_b;
            OP_SRL:   alu_result = alu_a >> shamt;
            OP_SRA:   alu_result = XLEN'($signed(alu_a) >>> shamt);
            OP_OR:    alu_result = alu_a | alu_b;
            OP_AND:   alu_result = alu_a & alu_b;
            OP_PASSB: alu_result = alu_b;
            default:  alu_result = '0;
        endcase
    end

    // EX/MEM copy of the result; free-running, no enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
        end else begin
            alu_result_q <= alu_result;
        end
    end

    assign br_eq = (br_a == br_b);
    assign br_lt = br_u ? (br_a < br_b) : ($signed(br_a) < $signed(br_b));

    // Only the low PCW bits of the offset can affect a PCW-bit target
    assign imm_hi_unused = ^imm[XLEN-1:PCW];

    assign pc_branch = pc_sel ? (if_id_pc + imm[PCW-1:0]) : (if_id_pc + PCW'(4));
    assign branch    = branch_indicator & pc_sel & ~stall;

endmodule

// File: tb/tb_ex_branch_unit.sv
// Scoreboard bench for ex_branch_unit: expectations are queued as stimulus is
// driven and drained against the DUT outputs away from the clock edge.
module tb_ex_branch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_a = '0, alu_b = '0;
    logic [3:0]  alu_sel = '0;
    logic [31:0] alu_result, alu_result_q;
    logic [31:0] br_a = '0, br_b = '0;
    logic        br_u = 1'b0;
    logic        br_eq, br_lt;
    logic        pc_sel = 1'b0;
    logic [31:0] imm = '0;
    logic [7:0]  if_id_pc = '0;
    logic        branch_indicator = 1'b0;
    logic        stall = 1'b0;
    logic        branch;
    logic [7:0]  pc_branch;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    localparam int K_RES = 0, K_RESQ = 1, K_EQ = 2, K_LT = 3, K_PC = 4, K_BR = 5;

    ex_branch_unit #(.XLEN(32), .PCW(8)) dut (
        .clk(clk), .rst(rst),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_result_q(alu_result_q),
        .br_a(br_a), .br_b(br_b), .br_u(br_u),
        .br_eq(br_eq), .br_lt(br_lt),
        .pc_sel(pc_sel), .imm(imm), .if_id_pc(if_id_pc),
        .branch_indicator(branch_indicator), .stall(stall),
        .branch(branch), .pc_branch(pc_branch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v, input string t);
        exp_t e;
        e.kind = k; e.val = v; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RES:   act = alu_result;
                K_RESQ:  act = alu_result_q;
                K_EQ:    act = {31'b0, br_eq};
                K_LT:    act = {31'b0, br_lt};
                K_PC:    act = {24'b0, pc_branch};
                default: act = {31'b0, branch};
            endcase
            check(e.tag, act, e.val);
        end
    endtask

    // Independent reference: SUB via two's complement, SRA via explicit fill
    function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (sel)
            4'b0000: return a + b;
            4'b1000: return a + ~b + 32'd1;
            4'b0001: return a << s;
            4'b0010: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> s;
            4'b1101: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic alu_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        @(negedge clk);
        alu_sel = sel; alu_a = a; alu_b = b;
        push(K_RES, exp, tag);
        #1 drain();
    endtask

    task automatic cmp(input logic [31:0] a, input logic [31:0] b, input logic u,
                       input logic exp_eq, input logic exp_lt, input string tag);
        @(negedge clk);
        br_a = a; br_b = b; br_u = u;
        push(K_EQ, {31'b0, exp_eq}, {tag, "_eq"});
        push(K_LT, {31'b0, exp_lt}, {tag, "_lt"});
        #1 drain();
    endtask

    task automatic brc(input logic ps, input logic [31:0] im, input logic [7:0] pc,
                       input logic bi, input logic st, input logic [7:0] exp_pc,
                       input logic exp_br, input string tag);
        @(negedge clk);
        pc_sel = ps; imm = im; if_id_pc = pc; branch_indicator = bi; stall = st;
        push(K_PC, {24'b0, exp_pc}, {tag, "_pc"});
        push(K_BR, {31'b0, exp_br}, {tag, "_br"});
        #1 drain();
    endtask

    logic [3:0] ops [12] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                              4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111, 4'b1010};

    initial begin
        // Reset state
        #2;
        push(K_RESQ, 32'h0, "reset_q");
        drain();
        @(negedge clk);
        rst = 1'b1;

        alu_op(4'b0000, 32'd5, 32'd3, 32'd8, "add_5_3");
        alu_op(4'b1000, 32'd5, 32'd3, 32'd2, "sub_5_3");
        alu_op(4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_0_1");
        alu_op(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0, "add_wrap");
        alu_op(4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
        alu_op(4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
        alu_op(4'b0001, 32'h8000_0000, 32'd4, 32'h0, "sll");
        alu_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
        alu_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        alu_op(4'b1111, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, "passb");
        alu_op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
        alu_op(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or");
        alu_op(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
        alu_op(4'b1010, 32'h1234_5678, 32'h1, 32'h0, "illegal_op");
        alu_op(4'b1101, 32'h7000_0000, 32'd33, 32'h3800_0000, "sra_shamt_low5");

        for (int i = 0; i < 24; i++) begin
            logic [3:0]  sel;
            logic [31:0] a, b;
            sel = ops[$urandom_range(0, 11)];
            a = $urandom; b = $urandom;
            alu_op(sel, a, b, ref_alu(sel, a, b), $sformatf("rand_alu_%0d_op%b", i, sel));
        end

        cmp(32'hFFFF_FFFE, 32'd2, 1'b0, 1'b0, 1'b1, "cmp_signed");
        cmp(32'hFFFF_FFFE, 32'd2, 1'b1, 1'b0, 1'b0, "cmp_unsigned");
        cmp(32'd2, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, "cmp_unsigned_rev");
        cmp(32'd7, 32'd7, 1'b0, 1'b1, 1'b0, "cmp_equal");
        cmp(32'd7, 32'd7, 1'b1, 1'b1, 1'b0, "cmp_equal_u");

        brc(1'b1, 32'hFFFF_FFF8, 8'h10, 1'b1, 1'b0, 8'h08, 1'b1, "taken");
        brc(1'b1, 32'hFFFF_FFF8, 8'h10, 1'b1, 1'b1, 8'h08, 1'b0, "stalled");
        brc(1'b0, 32'hFFFF_FFF8, 8'hFC, 1'b1, 1'b0, 8'h00, 1'b0, "not_taken_wrap");
        brc(1'b1, 32'h0000_0020, 8'h10, 1'b0, 1'b0, 8'h30, 1'b0, "no_indicator");
        brc(1'b1, 32'h0000_0100, 8'hF0, 1'b1, 1'b0, 8'hF0, 1'b1, "imm_high_ignored");

        // Registered result and asynchronous reset
        @(negedge clk);
        alu_sel = 4'b0000; alu_a = 32'd1; alu_b = 32'd1;
        push(K_RESQ, 32'd2, "q_after_edge");
        @(posedge clk);
        #1 drain();
        @(negedge clk);
        alu_a = 32'd3;
        push(K_RESQ, 32'd2, "q_holds_between_edges");
        #1 drain();
        rst = 1'b0;
        push(K_RESQ, 32'd0, "q_async_clear");
        #1 drain();
        @(posedge clk);
        push(K_RESQ, 32'd0, "q_held_in_reset");
        #1 drain();
        @(negedge clk);
        rst = 1'b1;
        push(K_RESQ, 32'd0, "q_no_capture_on_release");
        #1 drain();
        @(posedge clk);
        push(K_RESQ, 32'd4, "q_first_capture");
        #1 drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
